// File: rtl/qbert_move_scheduler.sv
// Frame-synchronous Q*bert hop scheduler: buffers move commands in a small FIFO and
// walks the sprite anchor across the cube pyramid, updating only at end-of-frame.
module qbert_move_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned JUMP_LOG2   = 3,
  parameter int unsigned ROWS        = 6,
  parameter int          X_TOP       = 400,
  parameter int          Y_TOP       = 60,
  parameter int          HALF_W      = 50,
  parameter int          STEP_Y      = 75,
  parameter int          HOP_PX      = 20,
  parameter int unsigned FALL_FRAMES = 32,
  parameter int          FALL_SPEED  = 8
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic [2:0]  iCMD,
  input  logic        iCMD_VALID,
  output logic        oCMD_READY,
  input  logic        iNEW_FRAME,
  input  logic        iEND_FRAME,
  output logic [10:0] oX0,
  output logic [9:0]  oY0,
  output logic [2:0]  oROW,
  output logic [2:0]  oCOL,
  output logic        oMOVING,
  output logic        oFALL,
  output logic        oLAND
);

  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int          JUMP_LEN = 1 << JUMP_LOG2;
  localparam int          HALF_LEN = JUMP_LEN / 2;

  localparam logic [2:0] CmdUpRight = 3'b001;
  localparam logic [2:0] CmdUpLeft  = 3'b010;
  localparam logic [2:0] CmdDnRight = 3'b011;
  localparam logic [2:0] CmdDnLeft  = 3'b100;
  localparam logic [2:0] CmdRespawn = 3'b111;

  typedef enum logic [1:0] {StIdle, StJump, StFall} state_e;

  // Pyramid geometry: anchor of cube (r,c)
  function automatic logic signed [11:0] anchor_x(input logic signed [4:0] r,
                                                   input logic signed [4:0] c);
    anchor_x = 12'(X_TOP + (2 * int'(c) - int'(r)) * HALF_W);
  endfunction

  function automatic logic signed [11:0] anchor_y(input logic signed [4:0] r);
    anchor_y = 12'(Y_TOP + int'(r) * STEP_Y);
  endfunction

  logic [2:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  state_e            r_state, w_state_d;
  logic [7:0]        r_k, w_k_d;
  logic signed [11:0] r_xs, r_ys, r_dx, r_dy, w_xs_d, w_ys_d, w_dx_d, w_dy_d;
  logic [2:0]        r_tr, r_tc, w_tr_d, w_tc_d;
  logic [10:0]       r_x0, w_x0_d;
  logic [9:0]        r_y0, w_y0_d;
  logic [2:0]        r_row, r_col, w_row_d, w_col_d;
  logic              r_moving, r_fall, r_land, w_moving_d, w_fall_d, w_land_d;

  logic              w_push, w_pop, w_flush, w_is_move, w_legal;
  logic [2:0]        w_head;
  logic signed [4:0] w_row_s, w_col_s, w_tr, w_tc;
  logic signed [11:0] w_sx, w_sy;
  logic [7:0]        w_k_inc;
  int                w_jx, w_jy, w_fy;

  assign oCMD_READY = (r_count != CNT_W'(FIFO_DEPTH)) && (r_state != StFall);
  assign w_push     = iCMD_VALID && oCMD_READY;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_row_s    = $signed({2'b00, r_row});
  assign w_col_s    = $signed({2'b00, r_col});
  assign w_sx       = anchor_x(w_row_s, w_col_s);
  assign w_sy       = anchor_y(w_row_s);
  assign w_k_inc    = r_k + 8'd1;

  // Decode the head command into a target cube and its legality
  always_comb begin
    w_tr      = w_row_s;
    w_tc      = w_col_s;
    w_is_move = 1'b1;
    case (w_head)
      CmdUpRight: w_tr = w_row_s - 5'sd1;
      CmdUpLeft: begin
        w_tr = w_row_s - 5'sd1;
        w_tc = w_col_s - 5'sd1;
      end
      CmdDnRight: begin
        w_tr = w_row_s + 5'sd1;
        w_tc = w_col_s + 5'sd1;
      end
      CmdDnLeft:  w_tr = w_row_s + 5'sd1;
      default:    w_is_move = 1'b0;
    endcase
  end

  assign w_legal = (w_tr >= 5'sd0) && (int'(w_tr) < int'(ROWS)) &&
                   (w_tc >= 5'sd0) && (w_tc <= w_tr);

  // Hop trajectory and fall position for the next frame
  always_comb begin
    w_jx = int'(r_xs) + ((int'(r_dx) * int'(w_k_inc)) >>> JUMP_LOG2);
    w_jy = int'(r_ys) + ((int'(r_dy) * int'(w_k_inc)) >>> JUMP_LOG2) -
           ((int'(w_k_inc) <= HALF_LEN) ? HOP_PX : 0);
    w_fy = int'(r_y0) + FALL_SPEED;
    if (w_fy > 1023) w_fy = 1023;
  end

  // FSM next-state and output registers; everything advances only on iEND_FRAME
  always_comb begin
    w_state_d  = r_state;
    w_k_d      = r_k;
    w_xs_d     = r_xs;
    w_ys_d     = r_ys;
    w_dx_d     = r_dx;
    w_dy_d     = r_dy;
    w_tr_d     = r_tr;
    w_tc_d     = r_tc;
    w_x0_d     = r_x0;
    w_y0_d     = r_y0;
    w_row_d    = r_row;
    w_col_d    = r_col;
    w_moving_d = r_moving;
    w_fall_d   = r_fall;
    // A raised landing pulse drops on the next cycle; frame start clears it too
    w_land_d   = r_land & ~(r_land | iNEW_FRAME);
    w_pop      = 1'b0;
    w_flush    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (iEND_FRAME && (r_count != '0)) begin
          w_pop = 1'b1;
          if (w_is_move && w_legal) begin
            w_xs_d     = w_sx;
            w_ys_d     = w_sy;
            w_dx_d     = anchor_x(w_tr, w_tc) - w_sx;
            w_dy_d     = anchor_y(w_tr) - w_sy;
            w_tr_d     = w_tr[2:0];
            w_tc_d     = w_tc[2:0];
            w_k_d      = '0;
            w_moving_d = 1'b1;
            w_state_d  = StJump;
          end else if (w_is_move) begin
            w_flush   = 1'b1;
            w_k_d     = '0;
            w_fall_d  = 1'b1;
            w_state_d = StFall;
          end else if (w_head == CmdRespawn) begin
            w_row_d  = '0;
            w_col_d  = '0;
            w_x0_d   = 11'(X_TOP);
            w_y0_d   = 10'(Y_TOP);
            w_land_d = 1'b1;
          end
        end
      end
      StJump: begin
        if (iEND_FRAME) begin
          w_k_d = w_k_inc;
          if (int'(w_k_inc) == JUMP_LEN) begin
            // Land exactly on the target anchor, no rounding residue
            w_x0_d     = 11'(r_xs + r_dx);
            w_y0_d     = 10'(r_ys + r_dy);
            w_row_d    = r_tr;
            w_col_d    = r_tc;
            w_moving_d = 1'b0;
            w_land_d   = 1'b1;
            w_state_d  = StIdle;
          end else begin
            w_x0_d = 11'(w_jx);
            w_y0_d = 10'(w_jy);
          end
        end
      end
      StFall: begin
        if (iEND_FRAME) begin
          if (r_k == 8'(FALL_FRAMES)) begin
            w_row_d   = '0;
            w_col_d   = '0;
            w_x0_d    = 11'(X_TOP);
            w_y0_d    = 10'(Y_TOP);
            w_fall_d  = 1'b0;
            w_state_d = StIdle;
          end else begin
            w_y0_d = 10'(w_fy);
            w_k_d  = w_k_inc;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and position registers
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state  <= StIdle;
      r_k      <= '0;
      r_xs     <= '0;
      r_ys     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_tr     <= '0;
      r_tc     <= '0;
      r_x0     <= 11'(X_TOP);
      r_y0     <= 10'(Y_TOP);
      r_row    <= '0;
      r_col    <= '0;
      r_moving <= 1'b0;
      r_fall   <= 1'b0;
      r_land   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_k      <= w_k_d;
      r_xs     <= w_xs_d;
      r_ys     <= w_ys_d;
      r_dx     <= w_dx_d;
      r_dy     <= w_dy_d;
      r_tr     <= w_tr_d;
      r_tc     <= w_tc_d;
      r_x0     <= w_x0_d;
      r_y0     <= w_y0_d;
      r_row    <= w_row_d;
      r_col    <= w_col_d;
      r_moving <= w_moving_d;
      r_fall   <= w_fall_d;
      r_land   <= w_land_d;
    end
  end

  // Command FIFO; a flush (illegal move) overrides any same-cycle push or pop
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= iCMD;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign oX0     = r_x0;
  assign oY0     = r_y0;
  assign oROW    = r_row;
  assign oCOL    = r_col;
  assign oMOVING = r_moving;
  assign oFALL   = r_fall;
  assign oLAND   = r_land;

endmodule

// File: tb/tb_qbert_move_scheduler.sv
// Scoreboard bench: each end-of-frame pushes its expected outputs; a monitor pops and
// compares them right after the frame-update clock edge.
module tb_qbert_move_scheduler;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic [2:0]  iCMD = 3'b000;
  logic        iCMD_VALID = 1'b0;
  logic        oCMD_READY;
  logic        iNEW_FRAME = 1'b0;
  logic        iEND_FRAME = 1'b0;
  logic [10:0] oX0;
  logic [9:0]  oY0;
  logic [2:0]  oROW, oCOL;
  logic        oMOVING, oFALL, oLAND;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x, y, row, col, mov, fall, land, rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  qbert_move_scheduler dut (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .iCMD       (iCMD),
    .iCMD_VALID (iCMD_VALID),
    .oCMD_READY (oCMD_READY),
    .iNEW_FRAME (iNEW_FRAME),
    .iEND_FRAME (iEND_FRAME),
    .oX0        (oX0),
    .oY0        (oY0),
    .oROW       (oROW),
    .oCOL       (oCOL),
    .oMOVING    (oMOVING),
    .oFALL      (oFALL),
    .oLAND      (oLAND)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".x0"},     int'(oX0),        e.x);
    chk({tag, ".y0"},     int'(oY0),        e.y);
    chk({tag, ".row"},    int'(oROW),       e.row);
    chk({tag, ".col"},    int'(oCOL),       e.col);
    chk({tag, ".moving"}, int'(oMOVING),    e.mov);
    chk({tag, ".fall"},   int'(oFALL),      e.fall);
    chk({tag, ".land"},   int'(oLAND),      e.land);
    chk({tag, ".ready"},  int'(oCMD_READY), e.rdy);
  endtask

  function automatic exp_t mk(input int x, input int y, input int row, input int col,
                              input int mov, input int fall, input int land, input int rdy);
    exp_t e;
    e.x = x; e.y = y; e.row = row; e.col = col;
    e.mov = mov; e.fall = fall; e.land = land; e.rdy = rdy;
    return e;
  endfunction

  // Monitor: compare after every frame-update edge
  always @(posedge iCLK) begin
    if (iEND_FRAME === 1'b1 && iRST_n === 1'b1) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_unexpected: got an update, expected none queued");
      end else begin
        mon_e = exp_q.pop_front();
        chk_all("frame", mon_e);
      end
    end
  end

  task automatic push(input logic [2:0] c);
    @(negedge iCLK);
    iCMD = c;
    iCMD_VALID = 1'b1;
    @(negedge iCLK);
    iCMD_VALID = 1'b0;
  endtask

  // One end-of-frame, optionally with a simultaneous command push
  task automatic frame(input exp_t e, input logic do_push, input logic [2:0] c);
    exp_q.push_back(e);
    @(negedge iCLK);
    iEND_FRAME = 1'b1;
    iCMD       = c;
    iCMD_VALID = do_push;
    @(negedge iCLK);
    iEND_FRAME = 1'b0;
    iCMD_VALID = 1'b0;
    iNEW_FRAME = 1'b1;
    @(negedge iCLK);
    iNEW_FRAME = 1'b0;
  endtask

  // Frames k=1..nk of a hop: floor-scaled delta plus lift during the first half
  task automatic hop(input int xs, input int ys, input int dx, input int dy,
                     input int r0, input int c0, input int rt, input int ct,
                     input int nk, input int rdy_mid, input int rdy_end);
    int px, py;
    for (int k = 1; k <= nk; k++) begin
      if (k == 8) begin
        frame(mk(xs + dx, ys + dy, rt, ct, 0, 0, 1, rdy_end), 1'b0, 3'b000);
      end else begin
        px = dx * k;
        py = dy * k;
        frame(mk(xs + (px >>> 3), ys + (py >>> 3) - ((k <= 4) ? 20 : 0), r0, c0, 1, 0, 0,
                 rdy_mid), 1'b0, 3'b000);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #12;
    chk_all("reset", mk(400, 60, 0, 0, 0, 0, 0, 1));
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (2) @(negedge iCLK);

    // Down-right (0,0)->(1,1): k=4 gives 425/77, k=8 lands at 450/135
    push(3'b011);
    chk("ready_one", int'(oCMD_READY), 1);
    frame(mk(400, 60, 0, 0, 1, 0, 0, 1), 1'b0, 3'b000);
    hop(400, 60, 50, 75, 0, 0, 1, 1, 8, 1, 1);
    chk("land_drop", int'(oLAND), 0);

    // Up-left (1,1)->(0,0): k=1 gives 443/105
    push(3'b010);
    frame(mk(450, 135, 1, 1, 1, 0, 0, 1), 1'b0, 3'b000);
    hop(450, 135, -50, -75, 1, 1, 0, 0, 8, 1, 1);

    // FIFO: three queued, push+pop at the frame keeps 3, fourth fills, fifth refused
    push(3'b011);
    push(3'b100);
    push(3'b001);
    chk("ready_three", int'(oCMD_READY), 1);
    frame(mk(400, 60, 0, 0, 1, 0, 0, 1), 1'b1, 3'b010);
    push(3'b000);
    chk("ready_full", int'(oCMD_READY), 0);
    push(3'b111);
    hop(400, 60, 50, 75, 0, 0, 1, 1, 8, 0, 0);
    // Down-left (1,1)->(2,1): anchor 400/210
    frame(mk(450, 135, 1, 1, 1, 0, 0, 1), 1'b0, 3'b000);
    hop(450, 135, -50, 75, 1, 1, 2, 1, 8, 1, 1);
    // Up-right (2,1)->(1,1)
    frame(mk(400, 210, 2, 1, 1, 0, 0, 1), 1'b0, 3'b000);
    hop(400, 210, 50, -75, 2, 1, 1, 1, 8, 1, 1);
    // Up-left (1,1)->(0,0)
    frame(mk(450, 135, 1, 1, 1, 0, 0, 1), 1'b0, 3'b000);
    hop(450, 135, -50, -75, 1, 1, 0, 0, 8, 1, 1);
    // The queued 000 is dropped; the 011 behind it starts on the next frame
    push(3'b011);
    frame(mk(400, 60, 0, 0, 0, 0, 0, 1), 1'b0, 3'b000);
    frame(mk(400, 60, 0, 0, 1, 0, 0, 1), 1'b0, 3'b000);
    hop(400, 60, 50, 75, 0, 0, 1, 1, 8, 1, 1);

    // Respawn from (1,1)
    push(3'b111);
    frame(mk(400, 60, 0, 0, 0, 0, 1, 1), 1'b0, 3'b000);
    chk("respawn_land_drop", int'(oLAND), 0);

    // Illegal up-right from (0,0): fall 32 frames to 316, then back to the top
    push(3'b001);
    frame(mk(400, 60, 0, 0, 0, 1, 0, 0), 1'b0, 3'b000);
    chk("fall_ready", int'(oCMD_READY), 0);
    push(3'b011);
    for (int i = 1; i <= 32; i++) frame(mk(400, 60 + 8 * i, 0, 0, 0, 1, 0, 0), 1'b0, 3'b000);
    frame(mk(400, 60, 0, 0, 0, 0, 0, 1), 1'b0, 3'b000);
    frame(mk(400, 60, 0, 0, 0, 0, 0, 1), 1'b0, 3'b000);

    // Async reset at k=3 with a command still queued
    push(3'b011);
    push(3'b100);
    frame(mk(400, 60, 0, 0, 1, 0, 0, 1), 1'b0, 3'b000);
    hop(400, 60, 50, 75, 0, 0, 1, 1, 3, 1, 1);
    @(negedge iCLK);
    iRST_n = 1'b0;
    #1;
    chk_all("async_reset", mk(400, 60, 0, 0, 0, 0, 0, 1));
    @(negedge iCLK);
    iRST_n = 1'b1;
    frame(mk(400, 60, 0, 0, 0, 0, 0, 1), 1'b0, 3'b000);

    repeat (3) @(negedge iCLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
